dsp_ctrl_ex_pipe: RTL and testbench



---
 rtl/dsp_ctrl_pkg.sv | 29 ++
 rtl/dsp_ctrl_ex_pipe_nest_cnt.sv | 31 +++
 rtl/dsp_ctrl_ex_pipe.sv | 103 ++++++++++
 tb/tb_dsp_ctrl_ex_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg: shared FSM/loop-order types and default widths for the DSP execution controller
`ifndef HW_DSP_PE_ROWS
`define HW_DSP_PE_ROWS 4
`endif
`ifndef HW_DSP_PE_COLS
`define HW_DSP_PE_COLS 4
`endif
`ifndef HW_BP_ACT_BUF_DEPTH
`define HW_BP_ACT_BUF_DEPTH 10
`endif
`ifndef HW_BP_WGT_BUF_DEPTH
`define HW_BP_WGT_BUF_DEPTH 10
`endif
`ifndef HW_BP_OUT_BUF_DEPTH
`define HW_BP_OUT_BUF_DEPTH 12
`endif
package dsp_ctrl_pkg;
  localparam int CFG_DIM_W = 8;
  localparam int CFG_ACT_AW = `HW_BP_ACT_BUF_DEPTH;
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {ORD_HW_K, ORD_K_HW} order_t;
  typedef struct packed {
    logic [CFG_DIM_W-1:0] k;
    logic [CFG_DIM_W-1:0] hw;
    logic [CFG_ACT_AW-1:0] cij;
    logic [CFG_ACT_AW+CFG_DIM_W-1:0] hwcij;
    order_t order;
  } cfg_t;
endpackage

// File: rtl/dsp_ctrl_ex_pipe_nest_cnt.sv
// nest_cnt: wrapping loop counter with two running base accumulators that clear on wrap
module nest_cnt #(
  parameter int CW = 8,
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] max,
  input  logic [BW-1:0] stride_a,
  input  logic [BW-1:0] stride_b,
  output logic [BW-1:0] base_a,
  output logic [BW-1:0] base_b,
  output logic          carry
);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == max;
  assign carry = en && wrap;
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      base_a <= '0;
      base_b <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      base_a <= wrap ? '0 : base_a + stride_a;
      base_b <= wrap ? '0 : base_b + stride_b;
    end
endmodule

// File: rtl/dsp_ctrl_ex_pipe.sv
// dsp_ctrl_ex_pipe: execution-phase loop controller emitting act/wgt/out buffer addresses and psum window
module dsp_ctrl_ex_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int ROWS = `HW_DSP_PE_ROWS,
  parameter int COLS = `HW_DSP_PE_COLS,
  parameter int DIM_W = CFG_DIM_W,
  parameter int ACT_AW = CFG_ACT_AW,
  parameter int WGT_AW = `HW_BP_WGT_BUF_DEPTH,
  parameter int OUT_AW = `HW_BP_OUT_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIM_W-1:0]        cfg_K,
  input  logic [DIM_W-1:0]        cfg_HW,
  input  logic [ACT_AW-1:0]       cfg_CIJ,
  input  logic [ACT_AW+DIM_W-1:0] cfg_HWCIJ,
  input  logic                    cfg_order,
  input  logic                    start,
  input  logic                    stall,
  output logic                    busy,
  output logic [ACT_AW-1:0]       act_addr,
  output logic [WGT_AW-1:0]       wgt_addr,
  output logic [OUT_AW-1:0]       out_addr,
  output logic                    addr_valid,
  output logic                    psum_sel,
  output logic                    done
);
  localparam int BW = ACT_AW + DIM_W;
  localparam int PW = $clog2(ROWS + 1);
  if (ROWS < 1 || COLS < 1) begin : g_bad_dims
    $error("dsp_ctrl_ex_pipe: ROWS and COLS must be positive");
  end
  state_t state;
  cfg_t cfg;
  logic ord, accept, zero_cfg, issue, d_carry, mid_carry, out_carry, seg_end;
  logic [DIM_W-1:0] mid_max, out_max;
  logic [BW-1:0] cij_s, d_base, d_base_unused, mid_a, mid_b, out_a, out_b, hw_base, k_base, kh_base;
  logic [BW-1:0] act_sum, wgt_sum, out_sum;
  logic [PW-1:0] psum_cnt;
  assign ord = cfg.order == ORD_K_HW;
  assign accept = state == IDLE && start;
  assign zero_cfg = cfg_K == '0 || cfg_HW == '0 || cfg_CIJ == '0;
  assign issue = state == RUN && !stall;
  assign mid_max = (ord ? cfg.hw : cfg.k) - 1'b1;
  assign out_max = (ord ? cfg.k : cfg.hw) - 1'b1;
  assign cij_s = {{DIM_W{1'b0}}, cfg.cij};
  // The counter playing the K role carries both k*CIJ and k*HWCIJ; the HW role only hw*CIJ
  assign hw_base = ord ? mid_a : out_a;
  assign k_base = ord ? out_a : mid_a;
  assign kh_base = mid_b + out_b;
  assign act_sum = hw_base + d_base;
  assign wgt_sum = k_base + d_base;
  assign out_sum = kh_base + hw_base + d_base;
  nest_cnt #(.CW(ACT_AW), .BW(BW)) u_depth (
    .clk(clk), .rst(rst), .clr(accept), .en(issue), .max(cfg.cij - 1'b1),
    .stride_a(BW'(1)), .stride_b('0), .base_a(d_base), .base_b(d_base_unused), .carry(d_carry)
  );
  nest_cnt #(.CW(DIM_W), .BW(BW)) u_mid (
    .clk(clk), .rst(rst), .clr(accept), .en(d_carry), .max(mid_max),
    .stride_a(cij_s), .stride_b(ord ? '0 : cfg.hwcij), .base_a(mid_a), .base_b(mid_b), .carry(mid_carry)
  );
  nest_cnt #(.CW(DIM_W), .BW(BW)) u_outer (
    .clk(clk), .rst(rst), .clr(accept), .en(mid_carry), .max(out_max),
    .stride_a(cij_s), .stride_b(ord ? cfg.hwcij : '0), .base_a(out_a), .base_b(out_b), .carry(out_carry)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      cfg <= '0;
      act_addr <= '0;
      wgt_addr <= '0;
      out_addr <= '0;
      addr_valid <= 1'b0;
      done <= 1'b0;
      seg_end <= 1'b0;
      psum_cnt <= '0;
      psum_sel <= 1'b0;
    end else begin
      addr_valid <= issue;
      done <= out_carry || (accept && zero_cfg);
      if (accept) cfg <= '{k: cfg_K, hw: cfg_HW, cij: cfg_CIJ, hwcij: cfg_HWCIJ, order: order_t'(cfg_order)};
      if (accept && !zero_cfg) begin
        state <= RUN;
        busy <= 1'b1;
      end else if (out_carry) begin
        state <= IDLE;
        busy <= 1'b0;
      end
      if (issue) begin
        act_addr <= act_sum[ACT_AW-1:0];
        wgt_addr <= wgt_sum[WGT_AW-1:0];
        out_addr <= out_sum[OUT_AW-1:0];
      end
      // seg_end marks the output beat with d = CIJ-1 and survives stalls so the window is not lost
      if (!stall) begin
        seg_end <= d_carry;
        psum_sel <= seg_end || psum_cnt != '0;
        psum_cnt <= seg_end ? PW'(ROWS - 1) : psum_cnt - PW'(psum_cnt != '0);
      end
    end
endmodule

// File: tb/tb_dsp_ctrl_ex_pipe.sv
// tb_dsp_ctrl_ex_pipe: directed checks of beat sequence, timing, stall, psum window, back-to-back and reset
module tb_dsp_ctrl_ex_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cfg_K = '0, cfg_HW = '0;
  logic [9:0] cfg_CIJ = '0;
  logic [17:0] cfg_HWCIJ = '0;
  logic cfg_order = 1'b0, start = 1'b0, stall = 1'b0;
  logic busy, addr_valid, psum_sel, done;
  logic [9:0] act_addr, wgt_addr;
  logic [11:0] out_addr;
  int checks = 0, errors = 0, cyc = 0, t0 = 0, t1 = 0;
  bit v_log [0:8191], b_log [0:8191], p_log [0:8191], dn_log [0:8191], s_log [0:8191];
  logic [31:0] beat_q[$], exp_q[$], ref_q[$];

  always #5 clk = ~clk;

  dsp_ctrl_ex_pipe #(.ROWS(4), .COLS(4), .DIM_W(8), .ACT_AW(10), .WGT_AW(10), .OUT_AW(12)) dut (
    .clk(clk), .rst(rst), .cfg_K(cfg_K), .cfg_HW(cfg_HW), .cfg_CIJ(cfg_CIJ), .cfg_HWCIJ(cfg_HWCIJ),
    .cfg_order(cfg_order), .start(start), .stall(stall), .busy(busy), .act_addr(act_addr),
    .wgt_addr(wgt_addr), .out_addr(out_addr), .addr_valid(addr_valid), .psum_sel(psum_sel), .done(done)
  );

  always @(posedge clk) begin
    if (cyc < 8192) s_log[cyc] = stall;
    cyc = cyc + 1;
  end

  always @(negedge clk)
    if (cyc < 8192) begin
      v_log[cyc] = addr_valid;
      b_log[cyc] = busy;
      p_log[cyc] = psum_sel;
      dn_log[cyc] = done;
      if (addr_valid) beat_q.push_back({act_addr, wgt_addr, out_addr});
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit lg(int sel, int c);
    return sel == 0 ? v_log[c] : sel == 1 ? b_log[c] : sel == 2 ? p_log[c] : dn_log[c];
  endfunction

  function automatic int cnt_hi(int sel, int a, int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(lg(sel, c));
    return n;
  endfunction

  function automatic int first_hi(int sel, int a, int b);
    for (int c = a; c <= b; c++) if (lg(sel, c)) return c - a;
    return -1;
  endfunction

  function automatic int last_hi(int sel, int a, int b);
    for (int c = b; c >= a; c--) if (lg(sel, c)) return c - a;
    return -1;
  endfunction

  function automatic logic [31:0] at(int i);
    return i < beat_q.size() ? beat_q[i] : 32'hdeadbeef;
  endfunction

  task automatic cfg_set(input int k, input int hw, input int cij, input int ord);
    cfg_K = 8'(k);
    cfg_HW = 8'(hw);
    cfg_CIJ = 10'(cij);
    cfg_HWCIJ = 18'(hw * cij);
    cfg_order = ord[0];
  endtask

  task automatic go(input int k, input int hw, input int cij, input int ord);
    @(negedge clk);
    cfg_set(k, hw, cij, ord);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic model(input int k, input int hw, input int cij, input int ord);
    int hwv, kv;
    for (int o = 0; o < (ord != 0 ? k : hw); o++)
      for (int m = 0; m < (ord != 0 ? hw : k); m++)
        for (int d = 0; d < cij; d++) begin
          hwv = ord != 0 ? m : o;
          kv = ord != 0 ? o : m;
          exp_q.push_back({10'(hwv * cij + d), 10'(kv * cij + d), 12'(kv * hw * cij + hwv * cij + d)});
        end
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_count"}, beat_q.size(), exp_q.size());
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) chk(tag, beat_q[i], exp_q[i]);
  endtask

  initial begin
    int mm, stalled, w;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({busy, addr_valid, psum_sel, done}), 0);
    chk("rst_addr", {act_addr, wgt_addr, out_addr}, 0);
    rst = 1'b0;
    // Baseline: K=2 HW=3 CIJ=4, HW outer
    beat_q.delete();
    go(2, 3, 4, 0);
    repeat (35) @(negedge clk);
    exp_q.delete();
    model(2, 3, 4, 0);
    cmp_seq("t1_seq");
    chk("t1_beat3", at(3), {10'd3, 10'd3, 12'd3});
    chk("t1_beat4", at(4), {10'd0, 10'd4, 12'd12});
    chk("t1_valid_n", cnt_hi(0, t0, t0 + 34), 24);
    chk("t1_first_valid", first_hi(0, t0, t0 + 34), 2);
    chk("t1_last_valid", last_hi(0, t0, t0 + 34), 25);
    chk("t1_done_cyc", first_hi(3, t0, t0 + 34), 25);
    chk("t1_done_n", cnt_hi(3, t0, t0 + 34), 1);
    chk("t1_busy_first", first_hi(1, t0, t0 + 34), 1);
    chk("t1_busy_last", last_hi(1, t0, t0 + 34), 24);
    ref_q = beat_q;
    // Same tile, K outer
    beat_q.delete();
    go(2, 3, 4, 1);
    repeat (35) @(negedge clk);
    exp_q.delete();
    model(2, 3, 4, 1);
    cmp_seq("t2_seq");
    chk("t2_beat4", at(4), {10'd4, 10'd0, 12'd4});
    chk("t2_done_cyc", first_hi(3, t0, t0 + 34), 25);
    beat_q.sort();
    ref_q.sort();
    chk("t2_multiset_n", beat_q.size(), ref_q.size());
    for (int i = 0; i < beat_q.size() && i < ref_q.size(); i++) chk("t2_multiset", beat_q[i], ref_q[i]);
    // psum window retrigger: CIJ=2, ROWS=4
    go(1, 2, 2, 0);
    repeat (20) @(negedge clk);
    chk("t3_psum_first", first_hi(2, t0, t0 + 19), 4);
    chk("t3_psum_last", last_hi(2, t0, t0 + 19), 9);
    chk("t3_psum_n", cnt_hi(2, t0, t0 + 19), 6);
    // Random 30% stall
    beat_q.delete();
    go(3, 2, 5, 0);
    for (int i = 0; i < 150; i++) begin
      stall = $urandom_range(0, 99) < 30;
      @(negedge clk);
    end
    stall = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.delete();
    model(3, 2, 5, 0);
    cmp_seq("t4_seq");
    chk("t4_valid_n", cnt_hi(0, t0, t0 + 158), 30);
    chk("t4_done_n", cnt_hi(3, t0, t0 + 158), 1);
    chk("t4_done_last", first_hi(3, t0, t0 + 158), last_hi(0, t0, t0 + 158));
    mm = 0;
    stalled = 0;
    for (int c = t0 + 1; c <= t0 + 157; c++)
      if (b_log[c]) begin
        stalled += int'(s_log[c]);
        if (v_log[c + 1] != !s_log[c]) mm++;
      end
    chk("t4_stall_valid", mm, 0);
    chk("t4_some_stall", 32'(stalled > 0), 1);
    // Back-to-back with an ignored start while busy
    beat_q.delete();
    go(1, 2, 2, 0);
    cfg_set(3, 3, 7, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t5_done_wait", 32'(done), 1);
    cfg_set(2, 1, 3, 0);
    start = 1'b1;
    t1 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.delete();
    model(1, 2, 2, 0);
    model(2, 1, 3, 0);
    cmp_seq("t5_seq");
    chk("t5_start2_cyc", t1 - t0, 5);
    chk("t5_done_n", cnt_hi(3, t0, t0 + 24), 2);
    chk("t5_done2_cyc", last_hi(3, t0, t0 + 24), 12);
    chk("t5_valid2_first", first_hi(0, t0 + 6, t0 + 24), 1);
    // Zero-size tile
    go(2, 0, 4, 0);
    repeat (8) @(negedge clk);
    chk("t6_done_cyc", first_hi(3, t0, t0 + 8), 1);
    chk("t6_done_n", cnt_hi(3, t0, t0 + 8), 1);
    chk("t6_valid_n", cnt_hi(0, t0, t0 + 8), 0);
    chk("t6_busy_n", cnt_hi(1, t0, t0 + 8), 0);
    // Reset mid-tile
    go(2, 3, 4, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_ctl", 32'({busy, addr_valid, psum_sel, done}), 0);
    chk("t7_rst_addr", {act_addr, wgt_addr, out_addr}, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t7_busy_before", cnt_hi(1, t0 + 1, t0 + 4), 4);
    chk("t7_no_done", cnt_hi(3, t0, t0 + 34), 0);
    chk("t7_no_valid_after", cnt_hi(0, t0 + 6, t0 + 34), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
